// File: rtl/pipe_arb_ctrl.sv
// pipe_arb_ctrl: two-requester issue arbiter for a fixed-latency
// F = ((A+B)+(C-D))*D datapath, with shadow valid/id pipe and a
// credit-protected result FIFO.
// Ports: clk, rst_n (async, low); r0_/r1_ valid/ready/ops {A,B,C,D};
//   dp_a..dp_d registered operands out, dp_f result in;
//   res_valid/res_ready/res_data/res_id FIFO head; inflight count.
// Config: define PIPE_ARB_RR_EN for round-robin, else r0 fixed priority.
// LAT must be >= 1.
module pipe_arb_ctrl #(
  parameter int N   = 10,
  parameter int LAT = 3,
  parameter int FD  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic [4*N-1:0]           r0_ops,
  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic [4*N-1:0]           r1_ops,
  output logic [N-1:0]             dp_a,
  output logic [N-1:0]             dp_b,
  output logic [N-1:0]             dp_c,
  output logic [N-1:0]             dp_d,
  input  logic [N-1:0]             dp_f,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N-1:0]             res_data,
  output logic                     res_id,
  output logic [$clog2(FD+1)-1:0]  inflight
);

  localparam int IW = $clog2(FD+1);
  localparam int AW = (FD > 1) ? $clog2(FD) : 1;

  logic [IW-1:0]  inflight_q, inflight_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  rp_q, wp_q;
  logic [N-1:0]   mem_q [FD];
  logic [FD-1:0]  mid_q;
  logic [LAT:0]   sv_q, sid_q;
  logic [N-1:0]   a_q, b_q, c_q, d_q;
  logic [4*N-1:0] ops_sel;
  logic credit_ok, issue, pop, push;
  logic prio;

`ifdef PIPE_ARB_RR_EN
  logic prio_q;

  // High means r1 wins the next contended cycle; the last
  // granted requester always drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (issue) begin
      prio_q <= r0_ready;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  assign credit_ok = inflight_q < IW'(FD);

  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (rst_n && credit_ok) begin
      unique case (1'b1)
        (r0_valid & ~r1_valid):        r0_ready = 1'b1;
        (r1_valid & ~r0_valid):        r1_ready = 1'b1;
        (r0_valid & r1_valid & ~prio): r0_ready = 1'b1;
        (r0_valid & r1_valid & prio):  r1_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign issue   = r0_ready | r1_ready;
  assign ops_sel = r1_ready ? r1_ops : r0_ops;
  assign push    = sv_q[LAT];
  assign pop     = res_valid & res_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (issue & ~pop) inflight_d = inflight_q + IW'(1);
    else if (~issue & pop) inflight_d = inflight_q - IW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop) cnt_d = cnt_q + IW'(1);
    else if (~push & pop) cnt_d = cnt_q - IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      sv_q       <= '0;
      sid_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      rp_q       <= '0;
      wp_q       <= '0;
    end else begin
      if (issue) begin
        a_q <= ops_sel[4*N-1:3*N];
        b_q <= ops_sel[3*N-1:2*N];
        c_q <= ops_sel[2*N-1:N];
        d_q <= ops_sel[N-1:0];
      end
      // Stage k valid means dp_f will be valid at stage LAT.
      sv_q       <= {sv_q[LAT-1:0], issue};
      sid_q      <= {sid_q[LAT-1:0], r1_ready};
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (push) begin
        wp_q <= (wp_q == AW'(FD-1)) ? '0 : wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= (rp_q == AW'(FD-1)) ? '0 : rp_q + AW'(1);
      end
    end
  end

  // Result storage needs no reset; head is masked when empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      assert (cnt_q < IW'(FD))
        else $error("result FIFO write while full");
      mem_q[wp_q] <= dp_f;
      mid_q[wp_q] <= sid_q[LAT];
    end
  end

  assign res_valid = cnt_q != '0;
  assign res_data  = res_valid ? mem_q[rp_q] : '0;
  assign res_id    = res_valid & mid_q[rp_q];
  assign inflight  = inflight_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_c      = c_q;
  assign dp_d      = d_q;

endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// tb_pipe_arb_ctrl: random + directed bench with a transaction-level
// model (due-time event list and result queue) checked every cycle.
module tb_pipe_arb_ctrl;
  localparam int N   = 10;
  localparam int LAT = 3;
  localparam int FD  = 4;
  localparam int IW  = $clog2(FD+1);
  localparam int OW  = 4*N;
`ifdef PIPE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_valid = 1'b0, r1_valid = 1'b0, res_ready = 1'b0;
  logic [OW-1:0] r0_ops = '0, r1_ops = '0;
  logic r0_ready, r1_ready, res_valid, res_id;
  logic [N-1:0] dp_a, dp_b, dp_c, dp_d, dp_f, res_data;
  logic [IW-1:0] inflight;

  always #5 clk = ~clk;

  pipe_arb_ctrl #(.N(N), .LAT(LAT), .FD(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ops(r0_ops),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ops(r1_ops),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_f(dp_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .inflight(inflight)
  );

  // Behavioural 3-stage datapath.
  logic [N-1:0] s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk) begin
    s1 <= ((dp_a + dp_b) + (dp_c - dp_d)) * dp_d;
    s2 <= s1;
    s3 <= s2;
  end
  assign dp_f = s3;

  typedef struct {
    int          due;
    logic [N-1:0] v;
    logic        id;
  } ent_t;

  int checks = 0;
  int errors = 0;
  ent_t pq[$];
  ent_t rq[$];
  int m_inf = 0;
  bit m_ptr = 1'b0;
  int cyc = 0;
  logic [OW-1:0] m_dp = '0;
  bit eg0, eg1, d_r0, d_r1;
  int pops = 0;

  function automatic logic [N-1:0] fop(input logic [OW-1:0] o);
    logic [N-1:0] a, b, c, d;
    {a, b, c, d} = o;
    return ((a + b) + (c - d)) * d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    rq.delete();
    m_inf = 0;
    m_ptr = 1'b0;
    m_dp = '0;
  endtask

  task automatic check_all();
    bit ev;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst_n && m_inf < FD) begin
      if (r0_valid && r1_valid) begin
        if (RR && m_ptr) eg1 = 1'b1;
        else eg0 = 1'b1;
      end else if (r0_valid) eg0 = 1'b1;
      else if (r1_valid) eg1 = 1'b1;
    end
    ev = rq.size() > 0;
    chk("r0_ready", r0_ready, eg0);
    chk("r1_ready", r1_ready, eg1);
    chk("res_valid", res_valid, ev);
    chk("res_data", res_data, ev ? rq[0].v : 0);
    chk("res_id", res_id, ev ? rq[0].id : 0);
    chk("inflight", inflight, m_inf);
    chk("dp_a", dp_a, m_dp[4*N-1:3*N]);
    chk("dp_b", dp_b, m_dp[3*N-1:2*N]);
    chk("dp_c", dp_c, m_dp[2*N-1:N]);
    chk("dp_d", dp_d, m_dp[N-1:0]);
    d_r0 = r0_ready;
    d_r1 = r1_ready;
    if (res_valid && res_ready) pops++;
  endtask

  task automatic model_edge();
    bit pop;
    ent_t e;
    logic [OW-1:0] ops;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cyc++;
    pop = (rq.size() > 0) && res_ready;
    if (pop) e = rq.pop_front();
    while (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      rq.push_back(e);
    end
    if (eg0 || eg1) begin
      ops = eg1 ? r1_ops : r0_ops;
      e.due = cyc + LAT + 1;
      e.v = fop(ops);
      e.id = eg1;
      pq.push_back(e);
      m_dp = ops;
      m_ptr = eg0;
    end
    m_inf = m_inf + int'(eg0 || eg1) - int'(pop);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int nis;
  logic [1:0] gh [4];

  initial begin
    r0_valid = 1'b1;
    #2;
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_dp_a", dp_a, 0);
    r0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Single op from r0.
    r0_ops = {N'(5), N'(3), N'(7), N'(2)};
    r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 26);
    chk("single_id", res_id, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("single_inflight0", inflight, 0);

    // Modular wrap from r1.
    r1_ops = {N'(1000), N'(20), N'(0), N'(4)};
    r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_data", res_data, 992);
    chk("wrap_id", res_id, 1);
    res_ready = 1'b1;
    idle(2);

    // Contention.
    do_reset();
    res_ready = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0_ops = OW'({$urandom(), $urandom()});
      r1_ops = OW'({$urandom(), $urandom()});
      tick();
      gh[i] = {d_r1, d_r0};
    end
    for (int i = 0; i < 4; i++)
      chk("contend_grant", gh[i], (RR && i % 2 == 1) ? 2 : 1);
    idle(12);

    // Back-pressure.
    do_reset();
    res_ready = 1'b0;
    r0_valid = 1'b1;
    nis = 0;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      r0_ops = OW'({$urandom(), $urandom()});
      tick();
      nis += int'(d_r0);
    end
    chk("bp_issues", nis, 4);
    chk("bp_inflight", inflight, 4);
    chk("bp_r0_ready", r0_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    chk("bp_resume", d_r0, 1);
    chk("bp_inflight_again", inflight, 4);
    r0_valid = 1'b0;
    res_ready = 1'b1;
    idle(10);
    chk("bp_pops", pops, 5);

    // Reset mid-flight.
    do_reset();
    res_ready = 1'b0;
    r0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0_ops = OW'({$urandom(), $urandom()});
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_r0_ready", r0_ready, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_dp_a", dp_a, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    pops = 0;
    idle(8);
    chk("mid_rst_no_stale", pops, 0);
    res_ready = 1'b0;
    r0_ops = {N'(5), N'(3), N'(7), N'(2)};
    r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_fresh", res_data, 26);
    res_ready = 1'b1;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r0_valid = 1'($urandom_range(0, 1));
      r1_valid = 1'($urandom_range(0, 1));
      r0_ops = OW'({$urandom(), $urandom()});
      r1_ops = OW'({$urandom(), $urandom()});
      res_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    res_ready = 1'b1;
    idle(12);
    chk("drain_empty", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
